// File: rtl/montacargas_pkg.sv
// Shared motor command encodings and controller state encoding for the
// freight-elevator controller.
package montacargas_pkg;

  localparam logic [1:0] MOTOR_PARADO = 2'b00;
  localparam logic [1:0] MOTOR_SUBIR  = 2'b10;
  localparam logic [1:0] MOTOR_BAJAR  = 2'b01;

  typedef enum logic [1:0] {
    REPOSO,
    SUBIR,
    BAJAR,
    PUERTA
  } estado_t;

endpackage

// File: rtl/montacargas_ctrl_buscador.sv
// Combinational call finder: reports whether latched calls exist above,
// below or exactly at a given floor index.
module buscador_solicitudes #(
  parameter int N_PISOS = 5,
  parameter int W_PISO  = $clog2(N_PISOS)
) (
  input  logic [N_PISOS-1:0] pendientes_i,
  input  logic [W_PISO-1:0]  piso_i,
  output logic               hay_arriba_o,
  output logic               hay_abajo_o,
  output logic               hay_aqui_o
);

  // An out-of-range floor index simply finds nothing above or here.
  always_comb begin
    hay_arriba_o = 1'b0;
    hay_abajo_o  = 1'b0;
    hay_aqui_o   = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (W_PISO'(i) > piso_i) begin
        hay_arriba_o = hay_arriba_o | pendientes_i[i];
      end
      if (W_PISO'(i) < piso_i) begin
        hay_abajo_o = hay_abajo_o | pendientes_i[i];
      end
      if (W_PISO'(i) == piso_i) begin
        hay_aqui_o = hay_aqui_o | pendientes_i[i];
      end
    end
  end

endmodule

// File: rtl/montacargas_ctrl.sv
// Freight-elevator controller: latches floor calls, sweeps with a collective
// up/down policy, and times floor-to-floor travel and door dwell.
module montacargas_ctrl #(
  parameter int N_PISOS  = 5,
  parameter int W_PISO   = $clog2(N_PISOS),
  parameter int T_VIAJE  = 8,
  parameter int T_PUERTA = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] llamada_i,
  input  logic               paro_i,
  output logic [1:0]         motor_o,
  output logic [W_PISO-1:0]  piso_actual_o,
  output logic               puerta_abierta_o,
  output logic [N_PISOS-1:0] pendientes_o,
  output logic               sube_o
);

  import montacargas_pkg::*;

  localparam int W_CV = $clog2(T_VIAJE + 1);
  localparam int W_CP = $clog2(T_PUERTA + 1);
  localparam logic [W_CV-1:0]    FIN_VIAJE  = W_CV'(T_VIAJE - 1);
  localparam logic [W_CP-1:0]    FIN_PUERTA = W_CP'(T_PUERTA - 1);
  localparam logic [N_PISOS-1:0] UNO        = N_PISOS'(1);

  estado_t             estado_q, estado_d;
  logic [W_PISO-1:0]   piso_q, piso_d;
  logic [N_PISOS-1:0]  pend_q, pend_d;
  logic                sube_q, sube_d;
  logic [W_CV-1:0]     cv_q, cv_d;
  logic [W_CP-1:0]     cp_q, cp_d;

  logic [W_PISO-1:0]   piso_sig;
  logic [N_PISOS-1:0]  limpiar;
  logic                llamada_aqui;
  logic                arriba_act, abajo_act, aqui_act;
  logic                arriba_sig, abajo_sig, aqui_sig;

  // Floor the car reaches at the end of the current leg; only meaningful while travelling.
  assign piso_sig     = (estado_q == BAJAR) ? (piso_q - W_PISO'(1)) : (piso_q + W_PISO'(1));
  assign llamada_aqui = |(llamada_i & (UNO << piso_q));

  buscador_solicitudes #(
    .N_PISOS (N_PISOS),
    .W_PISO  (W_PISO)
  ) u_buscador_act (
    .pendientes_i (pend_q),
    .piso_i       (piso_q),
    .hay_arriba_o (arriba_act),
    .hay_abajo_o  (abajo_act),
    .hay_aqui_o   (aqui_act)
  );

  buscador_solicitudes #(
    .N_PISOS (N_PISOS),
    .W_PISO  (W_PISO)
  ) u_buscador_sig (
    .pendientes_i (pend_q),
    .piso_i       (piso_sig),
    .hay_arriba_o (arriba_sig),
    .hay_abajo_o  (abajo_sig),
    .hay_aqui_o   (aqui_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      piso_q   <= '0;
      pend_q   <= '0;
      sube_q   <= 1'b1;
      cv_q     <= '0;
      cp_q     <= '0;
    end else begin
      estado_q <= estado_d;
      piso_q   <= piso_d;
      pend_q   <= pend_d;
      sube_q   <= sube_d;
      cv_q     <= cv_d;
      cp_q     <= cp_d;
    end
  end

  // The floor being served is masked out of the call latch, so clearing beats a new call.
  always_comb begin
    estado_d = estado_q;
    piso_d   = piso_q;
    sube_d   = sube_q;
    cv_d     = cv_q;
    cp_d     = cp_q;
    limpiar  = '0;
    unique case (estado_q)
      REPOSO: begin
        cv_d = '0;
        cp_d = '0;
        if (aqui_act) begin
          estado_d = PUERTA;
          limpiar  = UNO << piso_q;
        end else if (arriba_act && abajo_act) begin
          estado_d = sube_q ? SUBIR : BAJAR;
        end else if (arriba_act) begin
          estado_d = SUBIR;
          sube_d   = 1'b1;
        end else if (abajo_act) begin
          estado_d = BAJAR;
          sube_d   = 1'b0;
        end
      end
      SUBIR, BAJAR: begin
        if (!paro_i) begin
          if (cv_q == FIN_VIAJE) begin
            cv_d   = '0;
            piso_d = piso_sig;
            if (aqui_sig) begin
              estado_d = PUERTA;
              limpiar  = UNO << piso_sig;
            end else if ((estado_q == SUBIR) ? arriba_sig : abajo_sig) begin
              estado_d = estado_q;
            end else begin
              estado_d = REPOSO;
            end
          end else begin
            cv_d = cv_q + W_CV'(1);
          end
        end
      end
      PUERTA: begin
        limpiar = UNO << piso_q;
        if (llamada_aqui) begin
          cp_d = '0;
        end else if (cp_q == FIN_PUERTA) begin
          cp_d     = '0;
          estado_d = REPOSO;
        end else begin
          cp_d = cp_q + W_CP'(1);
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
    pend_d = (pend_q | llamada_i) & ~limpiar;
  end

  always_comb begin
    motor_o = MOTOR_PARADO;
    if (!paro_i) begin
      if (estado_q == SUBIR) begin
        motor_o = MOTOR_SUBIR;
      end else if (estado_q == BAJAR) begin
        motor_o = MOTOR_BAJAR;
      end
    end
    puerta_abierta_o = (estado_q == PUERTA);
    piso_actual_o    = piso_q;
    pendientes_o     = pend_q;
    sube_o           = sube_q;
  end

endmodule

// File: tb/tb_montacargas_ctrl.sv
// Scoreboard bench for montacargas_ctrl: expected output changes and their
// spacing in cycles are queued by the stimulus and consumed by a monitor.
module tb_montacargas_ctrl;

  typedef struct packed {
    logic [1:0]  motor;
    logic [2:0]  piso;
    logic        puerta;
    logic [4:0]  pend;
    logic        sube;
    logic        chkDt;
    int unsigned dt;
    int unsigned tag;
  } esperado_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] llamada = '0;
  logic       paro = 1'b0;
  logic [1:0] motor;
  logic [2:0] piso;
  logic       puerta;
  logic [4:0] pend;
  logic       sube;

  esperado_t   cola[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nextTag = 0;
  logic        monitorOn = 1'b0;

  montacargas_ctrl #(
    .N_PISOS  (5),
    .W_PISO   (3),
    .T_VIAJE  (8),
    .T_PUERTA (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .llamada_i        (llamada),
    .paro_i           (paro),
    .motor_o          (motor),
    .piso_actual_o    (piso),
    .puerta_abierta_o (puerta),
    .pendientes_o     (pend),
    .sube_o           (sube)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input logic [1:0] m, input logic [2:0] p, input logic pu,
                         input logic [4:0] pe, input logic s, input logic chk,
                         input int unsigned dt);
    esperado_t e;
    e.motor  = m;
    e.piso   = p;
    e.puerta = pu;
    e.pend   = pe;
    e.sube   = s;
    e.chkDt  = chk;
    e.dt     = dt;
    e.tag    = nextTag;
    nextTag++;
    cola.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One-cycle call pulse: driven after an edge, sampled by the following edge.
  task automatic applyStimulus(input logic [4:0] v);
    @(posedge clk);
    #2 llamada = v;
    @(posedge clk);
    #2 llamada = '0;
  endtask

  task automatic checkOutput(input logic [11:0] obs, input int unsigned dt);
    esperado_t e;
    checks++;
    if (cola.size() == 0) begin
      errors++;
      $display("[TB] FAIL evento_extra: observado motor=%b piso=%0d puerta=%b pend=%b sube=%b, nada esperado",
               obs[11:10], obs[9:7], obs[6], obs[5:1], obs[0]);
    end else begin
      e = cola.pop_front();
      if (obs !== {e.motor, e.piso, e.puerta, e.pend, e.sube} || (e.chkDt && dt != e.dt)) begin
        errors++;
        $display("[TB] FAIL evento%0d: observado motor=%b piso=%0d puerta=%b pend=%b sube=%b dt=%0d, esperado motor=%b piso=%0d puerta=%b pend=%b sube=%b dt=%0d",
                 e.tag, obs[11:10], obs[9:7], obs[6], obs[5:1], obs[0], dt,
                 e.motor, e.piso, e.puerta, e.pend, e.sube, e.dt);
      end
    end
  endtask

  // Monitor: every change of the observable tuple is one output event.
  initial begin
    logic [11:0] prev;
    logic [11:0] obs;
    int unsigned ciclos;
    prev   = 'x;
    ciclos = 0;
    wait (monitorOn);
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      ciclos++;
      obs = {motor, piso, puerta, pend, sube};
      if (obs !== prev) begin
        checkOutput(obs, ciclos);
        ciclos = 0;
        prev   = obs;
      end
    end
  end

  initial begin
    // Reset values
    pushExp(2'b00, 3'd0, 1'b0, 5'b00000, 1'b1, 1'b0, 0);
    #1 rst_n = 1'b0;
    #1 monitorOn = 1'b1;
    waitCycles(3);
    #2 rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single call to floor 2");
    pushExp(2'b00, 3'd0, 1'b0, 5'b00100, 1'b1, 1'b0, 0);
    pushExp(2'b10, 3'd0, 1'b0, 5'b00100, 1'b1, 1'b1, 1);
    pushExp(2'b10, 3'd1, 1'b0, 5'b00100, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd2, 1'b1, 5'b00000, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd2, 1'b0, 5'b00000, 1'b1, 1'b1, 16);
    applyStimulus(5'b00100);
    waitCycles(40);

    $display("[TB] calls to 0 and 4 from floor 2, sube=1");
    pushExp(2'b00, 3'd2, 1'b0, 5'b10001, 1'b1, 1'b0, 0);
    pushExp(2'b10, 3'd2, 1'b0, 5'b10001, 1'b1, 1'b1, 1);
    pushExp(2'b10, 3'd3, 1'b0, 5'b10001, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd4, 1'b1, 5'b00001, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd4, 1'b0, 5'b00001, 1'b1, 1'b1, 16);
    pushExp(2'b01, 3'd4, 1'b0, 5'b00001, 1'b0, 1'b1, 1);
    pushExp(2'b01, 3'd3, 1'b0, 5'b00001, 1'b0, 1'b1, 8);
    pushExp(2'b01, 3'd2, 1'b0, 5'b00001, 1'b0, 1'b1, 8);
    pushExp(2'b01, 3'd1, 1'b0, 5'b00001, 1'b0, 1'b1, 8);
    pushExp(2'b00, 3'd0, 1'b1, 5'b00000, 1'b0, 1'b1, 8);
    pushExp(2'b00, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b1, 16);
    applyStimulus(5'b10001);
    waitCycles(90);

    $display("[TB] move to floor 1");
    pushExp(2'b00, 3'd0, 1'b0, 5'b00010, 1'b0, 1'b0, 0);
    pushExp(2'b10, 3'd0, 1'b0, 5'b00010, 1'b1, 1'b1, 1);
    pushExp(2'b00, 3'd1, 1'b1, 5'b00000, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd1, 1'b0, 5'b00000, 1'b1, 1'b1, 16);
    applyStimulus(5'b00010);
    waitCycles(30);

    $display("[TB] 1 -> 3 with an intermediate call to floor 2");
    pushExp(2'b00, 3'd1, 1'b0, 5'b01000, 1'b1, 1'b0, 0);
    pushExp(2'b10, 3'd1, 1'b0, 5'b01000, 1'b1, 1'b1, 1);
    pushExp(2'b10, 3'd1, 1'b0, 5'b01100, 1'b1, 1'b1, 3);
    pushExp(2'b00, 3'd2, 1'b1, 5'b01000, 1'b1, 1'b1, 5);
    pushExp(2'b00, 3'd2, 1'b0, 5'b01000, 1'b1, 1'b1, 16);
    pushExp(2'b10, 3'd2, 1'b0, 5'b01000, 1'b1, 1'b1, 1);
    pushExp(2'b00, 3'd3, 1'b1, 5'b00000, 1'b1, 1'b1, 8);
    pushExp(2'b00, 3'd3, 1'b0, 5'b00000, 1'b1, 1'b1, 16);
    applyStimulus(5'b01000);
    waitCycles(2);
    applyStimulus(5'b00100);
    waitCycles(50);

    $display("[TB] paro for 5 cycles during 3 -> 4");
    pushExp(2'b00, 3'd3, 1'b0, 5'b10000, 1'b1, 1'b0, 0);
    pushExp(2'b10, 3'd3, 1'b0, 5'b10000, 1'b1, 1'b1, 1);
    pushExp(2'b00, 3'd3, 1'b0, 5'b10000, 1'b1, 1'b1, 2);
    pushExp(2'b10, 3'd3, 1'b0, 5'b10000, 1'b1, 1'b1, 5);
    pushExp(2'b00, 3'd4, 1'b1, 5'b00000, 1'b1, 1'b1, 6);
    pushExp(2'b00, 3'd4, 1'b0, 5'b00000, 1'b1, 1'b1, 16);
    applyStimulus(5'b10000);
    waitCycles(3);
    #2 paro = 1'b1;
    waitCycles(5);
    #2 paro = 1'b0;
    waitCycles(30);

    $display("[TB] door re-trigger at floor 3, dwell count 10");
    pushExp(2'b00, 3'd4, 1'b0, 5'b01000, 1'b1, 1'b0, 0);
    pushExp(2'b01, 3'd4, 1'b0, 5'b01000, 1'b0, 1'b1, 1);
    pushExp(2'b00, 3'd3, 1'b1, 5'b00000, 1'b0, 1'b1, 8);
    pushExp(2'b00, 3'd3, 1'b0, 5'b00000, 1'b0, 1'b1, 27);
    applyStimulus(5'b01000);
    waitCycles(18);
    applyStimulus(5'b01000);
    waitCycles(22);

    $display("[TB] asynchronous reset during 3 -> 0");
    pushExp(2'b00, 3'd3, 1'b0, 5'b00001, 1'b0, 1'b0, 0);
    pushExp(2'b01, 3'd3, 1'b0, 5'b00001, 1'b0, 1'b1, 1);
    pushExp(2'b01, 3'd2, 1'b0, 5'b00001, 1'b0, 1'b1, 8);
    pushExp(2'b00, 3'd0, 1'b0, 5'b00000, 1'b1, 1'b0, 0);
    applyStimulus(5'b00001);
    waitCycles(11);
    #3 rst_n = 1'b0;
    waitCycles(2);
    #2 rst_n = 1'b1;
    waitCycles(3);

    $display("[TB] call to the current floor 0");
    pushExp(2'b00, 3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 0);
    pushExp(2'b00, 3'd0, 1'b1, 5'b00000, 1'b1, 1'b1, 1);
    pushExp(2'b00, 3'd0, 1'b0, 5'b00000, 1'b1, 1'b1, 16);
    applyStimulus(5'b00001);
    waitCycles(25);

    checks++;
    if (cola.size() != 0) begin
      errors++;
      $display("[TB] FAIL eventos_pendientes: quedan %0d, requeridos 0", cola.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/montacargas_ctrl.md
# montacargas_ctrl

Parametrised freight-elevator controller: latches floor calls, schedules travel with a collective up/down policy, times floor-to-floor travel and door dwell, and drives the two-bit motor command directly from its own state register. It supersedes the fixed 5-floor combinational state-to-motor decode with a complete sequential controller for N floors. It sits between the floor call buttons and the motor driver and door actuator.

## Interface
- N_PISOS, 5: number of floors, at least 2. Floor 0 is the bottom floor.
- W_PISO, $clog2(N_PISOS): width of the floor index.
- T_VIAJE, 8: clock cycles to travel one floor, at least 1.
- T_PUERTA, 16: clock cycles of door dwell, at least 1.
- clk  in  1  the only clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- llamada  in  N_PISOS  floor call requests, one bit per floor, sampled every cycle. Pulse or level is accepted.
- paro  in  1  emergency hold. While high, travel freezes.
- motor  out  2  motor command: 00 stopped, 10 up, 01 down. 11 is never driven.
- piso_actual  out  W_PISO  current or last-passed floor.
- puerta_abierta  out  1  door open.
- pendientes  out  N_PISOS  latched, unserved calls.
- sube  out  1  direction preference register: 1 up, 0 down.

## Operation
- Reset values:
  - state REPOSO, motor 00, piso_actual 0, puerta_abierta 0, pendientes 0, sube 1.
  - Both counters are 0.
- Call latching:
  - pendientes[i] <= pendientes[i] | llamada[i], except for the floor cleared in the same cycle.
  - On conflict, clearing wins.
- FSM states: REPOSO, SUBIR, BAJAR, PUERTA.
- REPOSO: the decision uses registered pendientes, in priority order.
  1. pendientes[piso_actual] set: go to PUERTA and clear that bit.
  2. Calls both above and below the current floor: go in the direction given by sube.
  3. Calls only above: SUBIR, sube <= 1.
  4. Calls only below: BAJAR, sube <= 0.
  5. No calls: stay in REPOSO.
- SUBIR / BAJAR:
  - The travel counter counts 0..T_VIAJE-1.
  - On the terminal count, piso_actual is incremented (SUBIR) or decremented (BAJAR) to the new floor f, and the counter returns to 0.
  - At that same edge, the next state is decided using f:
    - pendientes[f] set: PUERTA, clear bit f.
    - Otherwise, calls remain further in the current direction: keep moving.
    - Otherwise: REPOSO.
  - The controller never moves past floor 0 or floor N_PISOS-1.
- paro high in SUBIR/BAJAR:
  - The counter holds its value and motor = 00.
  - The state is unchanged, and travel resumes from the held count when paro falls.
  - paro has no effect in REPOSO or PUERTA; calls are still latched while it is high.
- PUERTA:
  - The dwell counter counts 0..T_PUERTA-1, then the FSM returns to REPOSO.
  - A call for piso_actual arriving during PUERTA is not latched and restarts the dwell counter at 0.
- Outputs are registered from the state:
  - motor = 10 in SUBIR, 01 in BAJAR, otherwise 00. It is also 00 while paro is high.
  - puerta_abierta = 1 only in PUERTA.

## Timing
- Call to latch: a call pulse at edge k sets pendientes at k+1.
- Call to motor: REPOSO decides at k+1, and the motor is active from k+2. A one-cycle pulse is sufficient.
- Floor-to-floor time: exactly T_VIAJE cycles with motor active, excluding paro cycles.
- Door cycle: puerta_abierta is high for exactly T_PUERTA cycles with no re-trigger. It then spends 1 cycle in REPOSO before the next move.
- Reset asserted mid-travel: all outputs go immediately to their reset values, asynchronously. piso_actual returns to 0 and the controller does not recalibrate.
- Calls to all floors in one cycle: every floor is served in sweep order, with no floor skipped.

## Structure
- Shared package montacargas_pkg holds:
  - MOTOR_PARADO=2'b00, MOTOR_SUBIR=2'b10, MOTOR_BAJAR=2'b01.
  - The state encoding REPOSO, SUBIR, BAJAR, PUERTA.
- Sub-module buscador_solicitudes (combinational):
  - Inputs: pendientes and a floor index.
  - Outputs: hay_arriba, hay_abajo, hay_aqui.
  - It is instantiated twice: once for piso_actual and once for the next floor.

## Test plan
- Reset, then a pulse llamada=5'b00100 (N=5, T_VIAJE=8, T_PUERTA=16):
  - motor=10 from 2 cycles after the pulse for 16 cycles.
  - piso_actual steps 1 then 2.
  - puerta_abierta high for 16 cycles; pendientes returns to 0.
- At floor 2 with sube=1 and calls to floors 0 and 4 set together: floor 4 is served first, then floor 0. motor stays 00 for the whole door dwell.
- While moving up from 1 to 3, a call to floor 2 arrives mid-travel: the car stops at 2 and the door opens, then it continues to 3.
- paro held for 5 cycles mid-travel: motor=00 during paro, and arrival is delayed by exactly 5 cycles.
- During PUERTA at floor 3, a pulse on llamada[3] at dwell count 10: the door stays open for 16 more cycles and pendientes[3] stays 0.
- rst_n dropped mid-travel: on the same cycle, motor=00, piso_actual=0 and pendientes=0, with no clock edge required.
